// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and counter sizing helper
// Contents: default porch/sync/active lengths for both axes, their totals,
//           cnt_width() returning the bits needed to hold 0..total-1.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Bits needed for a counter running 0..total-1 (at least one bit).
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

    localparam int DEF_CNT_W =
        cnt_width((DEF_H_TOTAL > DEF_V_TOTAL) ? DEF_H_TOTAL : DEF_V_TOTAL);
    localparam int DEF_FRAME_W = 8;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - registered raster outputs bundle
// Signals: hsync, vsync, de, x, y, line_start, frame_start, frame_count.
// master drives them (timing generator), slave consumes them (pixel source / DAC).
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int FRAME_W = DEF_FRAME_W
);
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start, frame_count
    );

    modport slave (
        input  hsync, vsync, de, x, y, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_axis.sv
// rtl/vga_timing_axis.sv - one raster axis: wrapping counter plus active/sync decode
// Ports: clk_i, rst_i (sync, active-high), adv_i (advance one step),
//        cnt_o (current position), wrap_o (advancing from the last position),
//        active_o (position inside the visible area), sync_o (position inside sync window).
module vga_timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             active_o,
    output logic             sync_o
);
    localparam int TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam int SYNC_START = ACTIVE + FRONT;
    localparam int SYNC_END   = SYNC_START + SYNC;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;
    // One extra bit so window edges equal to TOTAL (zero back porch) still compare correctly.
    logic [CNT_W:0]   cnt_ext;

    assign at_last = (cnt_q == LAST);
    assign wrap_o  = adv_i && at_last;
    assign cnt_ext = {1'b0, cnt_q};

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign active_o = (cnt_ext < (CNT_W+1)'(ACTIVE));
    assign sync_o   = (cnt_ext >= (CNT_W+1)'(SYNC_START)) &&
                      (cnt_ext <  (CNT_W+1)'(SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator
// Ports: clk_25m (pixel clock), rst (sync, active-high), pix_en (pixel advance enable),
//        vid (master modport: hsync, vsync, de, x, y, line_start, frame_start, frame_count).
// All outputs are registered one clock after the counter value they describe and
// hold while pix_en is low.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int HSYNC_NEG = 1,
    parameter int VSYNC_NEG = 1,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int FRAME_W   = DEF_FRAME_W
) (
    input  logic              clk_25m,
    input  logic              rst,
    input  logic              pix_en,
    vga_timing_gen_if.master  vid
);
    localparam logic HS_POL = (HSYNC_NEG != 0);
    localparam logic VS_POL = (VSYNC_NEG != 0);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap;
    logic             h_act, v_act;
    logic             h_sync, v_sync;

    vga_timing_axis #(
        .ACTIVE (H_ACTIVE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK), .CNT_W (CNT_W)
    ) u_h_axis (
        .clk_i (clk_25m), .rst_i (rst), .adv_i (pix_en),
        .cnt_o (h_cnt), .wrap_o (h_wrap), .active_o (h_act), .sync_o (h_sync)
    );

    // The vertical axis steps once per completed line.
    vga_timing_axis #(
        .ACTIVE (V_ACTIVE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK), .CNT_W (CNT_W)
    ) u_v_axis (
        .clk_i (clk_25m), .rst_i (rst), .adv_i (h_wrap),
        .cnt_o (v_cnt), .wrap_o (v_wrap), .active_o (v_act), .sync_o (v_sync)
    );

    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [FRAME_W-1:0] frame_count_q, frame_count_d;
    // Set once the counters wrapped past the last pixel of a frame; the count is
    // bumped when (0,0) is actually presented so it lines up with frame_start.
    logic               wrap_pend_q, wrap_pend_d;

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        frame_count_d = frame_count_q;
        wrap_pend_d   = wrap_pend_q;
        if (pix_en) begin
            x_d           = h_cnt;
            y_d           = v_cnt;
            de_d          = h_act && v_act;
            hsync_d       = h_sync ^ HS_POL;
            vsync_d       = v_sync ^ VS_POL;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (wrap_pend_q) begin
                frame_count_d = frame_count_q + 1'b1;
            end
            wrap_pend_d   = v_wrap;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= HS_POL;
            vsync_q       <= VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            wrap_pend_q   <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            wrap_pend_q   <= wrap_pend_d;
        end
    end

    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.de          = de_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (default, tiny, positive-sync modes)
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hf, hsw, hb, va, vf, vsw, vb, hneg, vneg, fw;
    } mode_t;

    typedef struct packed {
        logic [31:0] x, y;
        logic        de, hs, vs, ls, fs;
        logic [31:0] fc;
    } vid_t;

    typedef struct {
        vid_t a, b, c;
        bit   agg, agg_end;
        int   cyc;
    } entry_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) vif_a ();
    vga_timing_gen_if #(.CNT_W(3),  .FRAME_W(2)) vif_b ();
    vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(3)) vif_c ();

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33),
        .HSYNC_NEG(1), .VSYNC_NEG(1), .CNT_W(10), .FRAME_W(8)
    ) u_a (.clk_25m(clk), .rst(rst), .pix_en(pix_en), .vid(vif_a));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_NEG(1), .VSYNC_NEG(1), .CNT_W(3), .FRAME_W(2)
    ) u_b (.clk_25m(clk), .rst(rst), .pix_en(pix_en), .vid(vif_b));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .HSYNC_NEG(0), .VSYNC_NEG(0), .CNT_W(4), .FRAME_W(3)
    ) u_c (.clk_25m(clk), .rst(rst), .pix_en(pix_en), .vid(vif_c));

    function automatic mode_t mode_of(input int id);
        mode_t m;
        case (id)
            0:       m = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1, 8};
            1:       m = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1, 2};
            default: m = '{8, 2, 3, 2, 6, 2, 2, 1, 0, 0, 3};
        endcase
        return m;
    endfunction

    // Expected outputs for the n-th enabled pixel since reset, straight from the raster rules.
    function automatic vid_t model(input int id, input longint n);
        mode_t  m;
        vid_t   v;
        longint ht, vt, line, frame;
        int     x, y;
        m     = mode_of(id);
        ht    = longint'(m.ha + m.hf + m.hsw + m.hb);
        vt    = longint'(m.va + m.vf + m.vsw + m.vb);
        line  = n / ht;
        frame = line / vt;
        x     = int'(n % ht);
        y     = int'(line % vt);
        v     = '0;
        v.x   = 32'(x);
        v.y   = 32'(y);
        v.fc  = 32'(frame % (64'd1 << m.fw));
        v.de  = (x < m.ha) && (y < m.va);
        v.hs  = ((x >= m.ha + m.hf) && (x < m.ha + m.hf + m.hsw)) != (m.hneg != 0);
        v.vs  = ((y >= m.va + m.vf) && (y < m.va + m.vf + m.vsw)) != (m.vneg != 0);
        v.ls  = (x == 0);
        v.fs  = (x == 0) && (y == 0);
        return v;
    endfunction

    function automatic vid_t rst_val(input int id);
        mode_t m;
        vid_t  v;
        m    = mode_of(id);
        v    = '0;
        v.hs = (m.hneg != 0);
        v.vs = (m.vneg != 0);
        return v;
    endfunction

    function automatic vid_t got_of(input int id);
        vid_t g;
        g = '0;
        case (id)
            0: begin
                g.x = 32'(vif_a.x); g.y = 32'(vif_a.y); g.de = vif_a.de;
                g.hs = vif_a.hsync; g.vs = vif_a.vsync; g.ls = vif_a.line_start;
                g.fs = vif_a.frame_start; g.fc = 32'(vif_a.frame_count);
            end
            1: begin
                g.x = 32'(vif_b.x); g.y = 32'(vif_b.y); g.de = vif_b.de;
                g.hs = vif_b.hsync; g.vs = vif_b.vsync; g.ls = vif_b.line_start;
                g.fs = vif_b.frame_start; g.fc = 32'(vif_b.frame_count);
            end
            default: begin
                g.x = 32'(vif_c.x); g.y = 32'(vif_c.y); g.de = vif_c.de;
                g.hs = vif_c.hsync; g.vs = vif_c.vsync; g.ls = vif_c.line_start;
                g.fs = vif_c.frame_start; g.fc = 32'(vif_c.frame_count);
            end
        endcase
        return g;
    endfunction

    entry_t sb_q[$];
    vid_t   exp_v[3];
    longint n_pix  = 0;
    int     cyc_no = 0;

    int n_checks = 0;
    int n_errors = 0;

    int agg_a_de = 0, agg_a_hsl = 0, agg_a_ls = 0;
    int agg_b_de = 0, agg_b_fs = 0, agg_b_wrap = 0, prev_b_fc = -1;
    int agg_c_hsh = 0;

    task automatic chk(input int id, input int cyc, input vid_t g, input vid_t e);
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL dut%0d cycle %0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                     id, cyc, g.x, g.y, g.de, g.hs, g.vs, g.ls, g.fs, g.fc,
                     e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic chk_cnt(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: one scoreboard entry per clock, compared just after the edge.
    always @(posedge clk) begin
        entry_t ent;
        vid_t   ga, gb, gc;
        #1;
        if (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            ga  = got_of(0);
            gb  = got_of(1);
            gc  = got_of(2);
            chk(0, ent.cyc, ga, ent.a);
            chk(1, ent.cyc, gb, ent.b);
            chk(2, ent.cyc, gc, ent.c);
            if (ent.agg) begin
                if (ga.de)  agg_a_de++;
                if (!ga.hs) agg_a_hsl++;
                if (ga.ls)  agg_a_ls++;
                if (gb.de)  agg_b_de++;
                if (gb.fs)  agg_b_fs++;
                if (prev_b_fc == 3 && gb.fc == 0) agg_b_wrap++;
                prev_b_fc = int'(gb.fc);
                if (gc.hs)  agg_c_hsh++;
            end
            if (ent.agg_end) begin
                chk_cnt("a_de_pixels_line0", agg_a_de, 640);
                chk_cnt("a_hsync_low_pixels_line0", agg_a_hsl, 96);
                chk_cnt("a_line_start_count", agg_a_ls, 1);
                chk_cnt("b_de_pixels_800", agg_b_de, 204);
                chk_cnt("b_frame_start_count_800", agg_b_fs, 17);
                chk_cnt("b_frame_count_wraps", agg_b_wrap, 4);
                chk_cnt("c_hsync_high_pixels_800", agg_c_hsh, 159);
            end
        end
    end

    // Drive one cycle of stimulus and queue what every DUT must show after that edge.
    task automatic step(input bit r, input bit e, input bit agg, input bit agg_end);
        entry_t ent;
        @(negedge clk);
        rst    = r;
        pix_en = e;
        for (int i = 0; i < 3; i++) begin
            if (r)      exp_v[i] = rst_val(i);
            else if (e) exp_v[i] = model(i, n_pix);
        end
        if (r)      n_pix = 0;
        else if (e) n_pix++;
        ent.a       = exp_v[0];
        ent.b       = exp_v[1];
        ent.c       = exp_v[2];
        ent.agg     = agg;
        ent.agg_end = agg_end;
        ent.cyc     = cyc_no;
        cyc_no++;
        sb_q.push_back(ent);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) step(1'b0, 1'b1, 1'b1, i == 799);
        for (int i = 0; i < 600; i++) step(1'b0, (i % 4 == 0) || (i % 4 == 3), 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2600; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
